// File: rtl/kamus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kamus_pkg
// Description : Shared types and helpers for the kamus execute stage.
//               - ex_op_e    : execute operation encoding (5 bits; codes
//                              beyond OP_REMU are undefined and execute
//                              as ADD)
//               - ex_state_e : execute-stage FSM state encoding
//               - is_mul / is_div / is_rem / is_signed_a / is_signed_b :
//                              operation class predicates
// Revision    : 1.0 - initial release
// ============================================================================
package kamus_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_SLT    = 5'd2,
    OP_SLTU   = 5'd3,
    OP_XOR    = 5'd4,
    OP_OR     = 5'd5,
    OP_AND    = 5'd6,
    OP_SLL    = 5'd7,
    OP_SRL    = 5'd8,
    OP_SRA    = 5'd9,
    OP_MUL    = 5'd10,
    OP_MULH   = 5'd11,
    OP_MULHSU = 5'd12,
    OP_MULHU  = 5'd13,
    OP_DIV    = 5'd14,
    OP_DIVU   = 5'd15,
    OP_REM    = 5'd16,
    OP_REMU   = 5'd17
  } ex_op_e;

  // Kept as plain 2-bit constants so legacy tooling can consume them.
  typedef logic [1:0] ex_state_e;
  localparam ex_state_e ST_IDLE = 2'd0;
  localparam ex_state_e ST_ITER = 2'd1;
  localparam ex_state_e ST_DONE = 2'd2;

  function automatic logic is_mul(input ex_op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
  endfunction

  function automatic logic is_div(input ex_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic is_rem(input ex_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic is_signed_a(input ex_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(input ex_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/kamus_md_iter.sv
`default_nettype none
// ============================================================================
// Module      : kamus_md_iter
// Description : Iterative multiply/divide datapath, one bit per cycle.
//               Multiply: shift-add into a 2*XLEN product.
//               Divide  : restoring division, remainder in the upper half of
//                         the accumulator, quotient shifted into the lower.
// Ports       : clk_i, rst_ni     - clock, async active-low reset
//               flush_i           - abort any iteration in progress
//               start_i           - load operands and begin XLEN steps
//               op_i              - M-extension op (selects sign/result)
//               operand_a_i/b_i   - raw rs1 / rs2 values
//               done_o            - last step is being taken this cycle
//               result_o          - sign-corrected result, valid with done_o
// Revision    : 1.0 - initial release
// ============================================================================
module kamus_md_iter import kamus_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            start_i,
  input  ex_op_e          op_i,
  input  logic [XLEN-1:0] operand_a_i,
  input  logic [XLEN-1:0] operand_b_i,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CNT_W = $clog2(XLEN);

  logic              busy_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2*XLEN-1:0] acc_q;     // product, or {remainder, dividend/quotient}
  logic [XLEN-1:0]   opnd_q;    // |multiplicand| or |divisor|
  logic              div_q;
  logic              hi_q;      // select high half (MULH*) or remainder
  logic              neg_q;     // negate product / quotient
  logic              neg_rem_q; // remainder follows the dividend sign

  // Operand conditioning at start
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_abs, b_abs;
  logic            sel_hi;

  always_comb begin
    a_neg  = is_signed_a(op_i) & operand_a_i[XLEN-1];
    b_neg  = is_signed_b(op_i) & operand_b_i[XLEN-1];
    a_abs  = a_neg ? -operand_a_i : operand_a_i;
    b_abs  = b_neg ? -operand_b_i : operand_b_i;
    sel_hi = (op_i == OP_MULH) || (op_i == OP_MULHSU) || (op_i == OP_MULHU) || is_rem(op_i);
  end

  // One iteration step
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_trial;
  logic [XLEN:0]     div_diff;
  logic              div_ok;
  logic [XLEN-1:0]   div_rem;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] acc_step;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    // Partial remainder < divisor, so the shifted trial fits in XLEN+1 bits
    // and bit XLEN of the difference is a clean borrow flag.
    div_trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_trial - {1'b0, opnd_q};
    div_ok    = ~div_diff[XLEN];
    div_rem   = div_ok ? div_diff[XLEN-1:0] : div_trial[XLEN-1:0];
    div_next  = {div_rem, acc_q[XLEN-2:0], div_ok};
    acc_step  = div_q ? div_next : mul_next;
  end

  // Sign correction of the final step
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;

  always_comb begin
    prod_fix = neg_q ? -acc_step : acc_step;
    quo_fix  = neg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    rem_fix  = neg_rem_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
    if (div_q) begin
      result_o = hi_q ? rem_fix : quo_fix;
    end else begin
      result_o = hi_q ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
    end
  end

  assign done_o = busy_q && (cnt_q == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      div_q     <= 1'b0;
      hi_q      <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (flush_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start_i) begin
      busy_q    <= 1'b1;
      cnt_q     <= CNT_W'(XLEN - 1);
      acc_q     <= {{XLEN{1'b0}}, a_abs};
      opnd_q    <= b_abs;
      div_q     <= is_div(op_i);
      hi_q      <= sel_hi;
      neg_q     <= a_neg ^ b_neg;
      neg_rem_q <= a_neg;
    end else if (busy_q) begin
      acc_q <= acc_step;
      if (cnt_q == '0) begin
        busy_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/kamus_ex_md.sv
`default_nettype none
// ============================================================================
// Module      : kamus_ex_md
// Description : Registered execute stage with valid/ready on both sides.
//               ALU ops and M-op special cases complete in one cycle; other
//               M-ops iterate for XLEN cycles in kamus_md_iter.
// Ports       : clk_i, rst_ni             - clock, async active-low reset
//               flush_i                   - drop in-flight / held op
//               in_valid_i / in_ready_o   - request handshake
//               op_i, operand_a_i/b_i     - operation and operands
//               rd_i / rd_o               - destination tag in / out
//               out_valid_o / out_ready_i - result handshake
//               result_o                  - registered result
//               busy_o                    - iteration in progress
// Revision    : 1.0 - initial release
// ============================================================================
module kamus_ex_md import kamus_pkg::*; #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  ex_op_e          op_i,
  input  logic [XLEN-1:0] operand_a_i,
  input  logic [XLEN-1:0] operand_b_i,
  input  logic [RD_W-1:0] rd_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic [RD_W-1:0] rd_o,
  output logic            busy_o
);

  localparam int SH_W = $clog2(XLEN);

  ex_state_e       state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [RD_W-1:0] rd_q, rd_d;

  logic            accept;
  logic            md_op;
  logic            special;
  logic            iter_start;
  logic            iter_done;
  logic [XLEN-1:0] iter_result;

  assign in_ready_o  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready_i);
  assign out_valid_o = (state_q == ST_DONE);
  assign busy_o      = (state_q == ST_ITER);
  assign result_o    = result_q;
  assign rd_o        = rd_q;

  assign accept = in_valid_i && in_ready_o && !flush_i;
  assign md_op  = is_mul(op_i) || is_div(op_i);

  // Single-cycle ALU
  logic [SH_W-1:0] shamt;
  logic [XLEN-1:0] alu_res;

  always_comb begin
    shamt = operand_b_i[SH_W-1:0];
    case (op_i)
      OP_SUB:  alu_res = operand_a_i - operand_b_i;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(operand_a_i) < $signed(operand_b_i)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, operand_a_i < operand_b_i};
      OP_XOR:  alu_res = operand_a_i ^ operand_b_i;
      OP_OR:   alu_res = operand_a_i | operand_b_i;
      OP_AND:  alu_res = operand_a_i & operand_b_i;
      OP_SLL:  alu_res = operand_a_i << shamt;
      OP_SRL:  alu_res = operand_a_i >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(operand_a_i) >>> shamt);
      default: alu_res = operand_a_i + operand_b_i; // ADD and undefined codes
    endcase
  end

  // Divide special cases resolved without iterating
  logic            div_zero;
  logic            div_ovf;
  logic [XLEN-1:0] special_res;

  always_comb begin
    div_zero = is_div(op_i) && (operand_b_i == '0);
    div_ovf  = is_div(op_i) && is_signed_a(op_i) &&
               (operand_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (operand_b_i == '1);
    special  = div_zero || div_ovf;
    if (is_rem(op_i)) begin
      special_res = div_zero ? operand_a_i : '0;
    end else begin
      special_res = div_zero ? '1 : operand_a_i;
    end
  end

  // FSM and output register
  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    rd_d       = rd_q;
    iter_start = 1'b0;

    case (state_q)
      ST_ITER: begin
        if (iter_done) begin
          state_d  = ST_DONE;
          result_d = iter_result;
        end
      end
      ST_DONE: begin
        if (out_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: ;
    endcase

    // A new op may replace a consumed result in the same cycle.
    if (accept) begin
      rd_d = rd_i;
      if (md_op && !special) begin
        state_d    = ST_ITER;
        iter_start = 1'b1;
      end else begin
        state_d  = ST_DONE;
        result_d = md_op ? special_res : alu_res;
      end
    end

    if (flush_i) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      rd_q     <= rd_d;
    end
  end

  kamus_md_iter #(
    .XLEN (XLEN)
  ) u_md_iter (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .start_i     (iter_start),
    .op_i        (op_i),
    .operand_a_i (operand_a_i),
    .operand_b_i (operand_b_i),
    .done_o      (iter_done),
    .result_o    (iter_result)
  );

endmodule
`default_nettype wire

// File: tb/tb_kamus_ex_md.sv
`default_nettype none
// ============================================================================
// Module      : tb_kamus_ex_md
// Description : Scoreboard bench for kamus_ex_md. The driver pushes the
//               hand-computed result, tag and expected latency for every
//               accepted op; a monitor pops and compares on each consumed
//               output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kamus_ex_md;
  import kamus_pkg::*;

  localparam int XLEN = 32;
  localparam int RD_W = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b1;
  ex_op_e          op = OP_ADD;
  logic [XLEN-1:0] a = '0;
  logic [XLEN-1:0] b = '0;
  logic [RD_W-1:0] rd = '0;
  logic            in_ready, out_valid, busy;
  logic [XLEN-1:0] result;
  logic [RD_W-1:0] rd_out;

  kamus_ex_md #(.XLEN(XLEN), .RD_W(RD_W)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .op_i        (op),
    .operand_a_i (a),
    .operand_b_i (b),
    .rd_i        (rd),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .result_o    (result),
    .rd_o        (rd_out),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [XLEN-1:0] res;
    logic [RD_W-1:0] rd;
    int              acc;
    int              lat;   // 0 = latency not checked
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   last_acc = 0;
  int   last_wait = 0;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every consumed output must match the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h rd %0d expected none", result, rd_out);
      end else begin
        mon_e = sb.pop_front();
        chk($sformatf("result_rd%0d", mon_e.rd), result, mon_e.res);
        chk($sformatf("tag_rd%0d", mon_e.rd), {{(XLEN-RD_W){1'b0}}, rd_out},
            {{(XLEN-RD_W){1'b0}}, mon_e.rd});
        if (mon_e.lat > 0)
          chk($sformatf("latency_rd%0d", mon_e.rd), 32'(cyc - mon_e.acc), 32'(mon_e.lat));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the accept edge.
  task automatic send(input ex_op_e o, input logic [XLEN-1:0] av, input logic [XLEN-1:0] bv,
                      input logic [RD_W-1:0] r, input logic [XLEN-1:0] ex,
                      input int lat, input bit push);
    int w;
    w = 0;
    op = o; a = av; b = bv; rd = r; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      w++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready stayed 0, expected 1 for rd %0d", r);
    end else begin
      last_acc  = cyc;
      last_wait = w;
      if (push) sb.push_back('{ex, r, cyc, lat});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() > 0 && w < 100) begin
      w++;
      tick(1);
    end
    chk("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_busy"},      {31'd0, busy},      32'd0);
    chk({tag, "_in_ready"},  {31'd0, in_ready},  32'd1);
    chk({tag, "_result"},    result,             32'd0);
    chk({tag, "_rd"},        {27'd0, rd_out},    32'd0);
  endtask

  initial begin
    int first_acc;
    int seen;

    // Reset
    tick(3);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    tick(1);

    // ALU: overflow add, then four back-to-back ORs
    send(OP_ADD, 32'h7FFF_FFFF, 32'h1, 5'd1, 32'h8000_0000, 1, 1);
    first_acc = 0;
    for (int i = 0; i < 4; i++) begin
      send(OP_OR, 32'h1 << i, 32'h100, 5'(i + 2), (32'h1 << i) | 32'h100, 1, 1);
      if (i == 0) first_acc = last_acc;
    end
    chk("or_b2b_span", 32'(last_acc - first_acc), 32'd3);
    drain();

    // Remaining ALU ops
    send(OP_SUB,  32'd5,         32'd7,        5'd6,  32'hFFFF_FFFE, 1, 1);
    send(OP_SLT,  32'hFFFF_FFFF, 32'd1,        5'd7,  32'd1,         1, 1);
    send(OP_SLTU, 32'hFFFF_FFFF, 32'd1,        5'd8,  32'd0,         1, 1);
    send(OP_SRA,  32'h8000_0000, 32'd4,        5'd9,  32'hF800_0000, 1, 1);
    send(OP_SRL,  32'h8000_0000, 32'd4,        5'd10, 32'h0800_0000, 1, 1);
    send(OP_SLL,  32'h1,         32'd33,       5'd11, 32'h2,         1, 1);
    send(OP_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd12, 32'h0FF0_0FF0, 1, 1);
    send(OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd13, 32'hF000_F000, 1, 1);
    send(ex_op_e'(5'd25), 32'd3, 32'd4,        5'd14, 32'd7,         1, 1);
    drain();

    // Iterative multiply
    send(OP_MULH,  32'h8000_0000, 32'h8000_0000, 5'd15, 32'h4000_0000, 33, 1);
    send(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd16, 32'hFFFF_FFFE, 33, 1);
    send(OP_MUL,   32'd7,         32'hFFFF_FFFD, 5'd17, 32'hFFFF_FFEB, 33, 1);
    send(OP_MULHSU, 32'hFFFF_FFFF, 32'd2,        5'd18, 32'hFFFF_FFFF, 33, 1);
    drain();

    // Iterative divide
    send(OP_DIV,  32'd7,         32'hFFFF_FFFE, 5'd19, 32'hFFFF_FFFD, 33, 1);
    send(OP_REM,  32'd7,         32'hFFFF_FFFE, 5'd20, 32'd1,         33, 1);
    send(OP_REM,  32'hFFFF_FFF9, 32'd2,         5'd21, 32'hFFFF_FFFF, 33, 1);
    send(OP_DIVU, 32'd100,       32'd7,         5'd22, 32'd14,        33, 1);
    drain();

    // Special cases, single cycle
    send(OP_DIV,  32'd5,         32'd0,         5'd23, 32'hFFFF_FFFF, 1, 1);
    send(OP_REMU, 32'd5,         32'd0,         5'd24, 32'd5,         1, 1);
    send(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd25, 32'h8000_0000, 1, 1);
    send(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd26, 32'd0,         1, 1);
    drain();

    // Backpressure: hold the result for 10 cycles
    out_ready = 1'b0;
    send(OP_ADD, 32'd10, 32'd20, 5'd27, 32'd30, 0, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_result",    result,            32'd30);
      chk("hold_rd",        {27'd0, rd_out},   32'd27);
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_in_ready",  {31'd0, in_ready},  32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(OP_ADD, 32'd1, 32'd1, 5'd28, 32'd2, 1, 1);
    chk("release_same_cycle_accept", 32'(last_wait), 32'd0);
    drain();

    // Flush in the middle of a divide
    send(OP_DIV, 32'd1000, 32'd3, 5'd29, 32'd0, 0, 0);
    @(negedge clk);
    chk("iter_busy",     {31'd0, busy},     32'd1);
    chk("iter_in_ready", {31'd0, in_ready}, 32'd0);
    tick(9);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy",      {31'd0, busy},      32'd0);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready",  {31'd0, in_ready},  32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("flush_no_output", 32'(seen), 32'd0);
    tick(1);
    send(OP_ADD, 32'd2, 32'd2, 5'd30, 32'd4, 1, 1);
    drain();

    // Reset in the middle of a multiply
    send(OP_MUL, 32'd5, 32'd6, 5'd31, 32'd0, 0, 0);
    tick(5);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    tick(2);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("midreset_no_output", 32'(seen), 32'd0);
    tick(1);
    send(OP_SUB, 32'd9, 32'd4, 5'd3, 32'd5, 1, 1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
